// File: rtl/latch_bank_pkg.sv
// Shared types and helpers for the clocked latch bank.
// Mode encoding matches the 2-bit per-channel mode field on the top-level bus.
package latch_bank_pkg;

  typedef enum logic [1:0] {
    LB_LEVEL = 2'b00,
    LB_RISE  = 2'b01,
    LB_FALL  = 2'b10,
    LB_HOLD  = 2'b11
  } lb_mode_e;

  // Age counter width; keeps at least one bit when staleness is disabled.
  function automatic int lb_age_w(input int stale_cyc);
    return (stale_cyc <= 0) ? 1 : $clog2(stale_cyc + 1);
  endfunction

endpackage

// File: rtl/latch_bank_chan.sv
// One capture channel: edge history, captured data, update pulse, valid flag
// and a saturating age counter that drives the registered stale flag.
module latch_bank_chan
  import latch_bank_pkg::*;
#(
  parameter int           W         = 8,
  parameter int           STALE_CYC = 16,
  parameter logic [W-1:0] RST_VAL   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic [1:0]   mode,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         upd,
  output logic         valid,
  output logic         stale
);

  localparam int            AW  = lb_age_w(STALE_CYC);
  localparam logic [AW-1:0] SAT = AW'(STALE_CYC);

  lb_mode_e      w_mode;
  logic          w_cap;
  logic [W-1:0]  w_q_nxt;
  logic          w_upd_nxt;
  logic          w_valid_nxt;
  logic [AW-1:0] w_age_nxt;
  logic          w_stale_nxt;

  logic          r_en_d;
  logic [W-1:0]  r_q;
  logic          r_upd;
  logic          r_valid;
  logic [AW-1:0] r_age;
  logic          r_stale;

  assign w_mode = lb_mode_e'(mode);

  always_comb begin
    w_cap = 1'b0;
    case (w_mode)
      LB_LEVEL: w_cap = en;
      LB_RISE:  w_cap = en & ~r_en_d;
      LB_FALL:  w_cap = ~en & r_en_d;
      default:  w_cap = 1'b0;
    endcase
  end

  // Clear outranks a capture in the same cycle.
  always_comb begin
    w_q_nxt     = r_q;
    w_upd_nxt   = 1'b0;
    w_valid_nxt = r_valid;
    w_age_nxt   = r_age;
    if (clr) begin
      w_q_nxt     = RST_VAL;
      w_valid_nxt = 1'b0;
      w_age_nxt   = '0;
    end else if (w_cap) begin
      w_q_nxt     = din;
      w_upd_nxt   = 1'b1;
      w_valid_nxt = 1'b1;
      w_age_nxt   = '0;
    end else if (r_valid && (r_age != SAT)) begin
      w_age_nxt = r_age + 1'b1;
    end
  end

  assign w_stale_nxt = (STALE_CYC > 0) && w_valid_nxt && (w_age_nxt == SAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_d  <= 1'b0;
      r_q     <= RST_VAL;
      r_upd   <= 1'b0;
      r_valid <= 1'b0;
      r_age   <= '0;
      r_stale <= 1'b0;
    end else begin
      r_en_d  <= en;
      r_q     <= w_q_nxt;
      r_upd   <= w_upd_nxt;
      r_valid <= w_valid_nxt;
      r_age   <= w_age_nxt;
      r_stale <= w_stale_nxt;
    end
  end

  assign q     = r_q;
  assign upd   = r_upd;
  assign valid = r_valid;
  assign stale = r_stale;

endmodule

// File: rtl/latch_bank.sv
// Bank of CH independent clocked capture channels; the top only slices the
// flat buses and hands each slice to its own channel instance.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int           CH        = 4,
  parameter int           W         = 8,
  parameter int           STALE_CYC = 16,
  parameter logic [W-1:0] RST_VAL   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   en,
  input  logic [CH*W-1:0] din,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH*W-1:0] q,
  output logic [CH-1:0]   upd,
  output logic [CH-1:0]   valid,
  output logic [CH-1:0]   stale
);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    latch_bank_chan #(
      .W         (W),
      .STALE_CYC (STALE_CYC),
      .RST_VAL   (RST_VAL)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .en    (en[c]),
      .din   (din[c*W +: W]),
      .mode  (mode[2*c +: 2]),
      .clr   (clr[c]),
      .q     (q[c*W +: W]),
      .upd   (upd[c]),
      .valid (valid[c]),
      .stale (stale[c])
    );
  end

endmodule
